lifo_stack: RTL and testbench

Parameterised synchronous LIFO (hardware stack) with a 2^WORD_SIZE-entry by WORD_LEN-bit register-file store, single push/pop port and full/empty status. It is a general-purpose storage primitive for FPGA datapaths: return-address stacks, expression evaluation and similar. The current top-of-stack word is presented combinationally on the read port. Overflow and underflow status is reported so that callers can throttle pushes and pops.

---
 rtl/lifo_stack.sv | 106 ++++++++++
 tb/tb_lifo_stack.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack.sv
// Synchronous LIFO stack: 2^WORD_SIZE x WORD_LEN register file, combinational top-of-stack read.
// Define LIFO_STACK_STICKY_ERR_EN to turn of/uf into sticky overflow/underflow error flags.
module lifo_stack #(
    parameter int WORD_LEN  = 8,
    parameter int WORD_SIZE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rd,
    input  logic                wr,
    input  logic [WORD_LEN-1:0] w_data,
    output logic [WORD_LEN-1:0] r_data,
    output logic                of,
    output logic                uf
);

    localparam int DEPTH = 1 << WORD_SIZE;

    typedef logic [WORD_SIZE:0]   cnt_t;
    typedef logic [WORD_SIZE-1:0] ptr_t;

    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam ptr_t PTR_ONE  = ptr_t'(1);

    cnt_t                count_q, count_d;
    logic [WORD_LEN-1:0] mem_q [DEPTH];
    logic                mem_we;
    ptr_t                mem_waddr;
    ptr_t                top_idx;
    logic                full, empty;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    // At count == DEPTH the low pointer bits wrap to 0, so the subtraction still lands on DEPTH-1.
    assign top_idx = count_q[WORD_SIZE-1:0] - PTR_ONE;
    assign r_data  = empty ? '0 : mem_q[top_idx];

    always_comb begin
        count_d   = count_q;
        mem_we    = 1'b0;
        mem_waddr = count_q[WORD_SIZE-1:0];
        unique case ({rd, wr})
            2'b01: begin
                if (!full) begin
                    mem_we  = 1'b1;
                    count_d = count_q + CNT_ONE;
                end
            end
            2'b10: begin
                if (!empty) begin
                    count_d = count_q - CNT_ONE;
                end
            end
            2'b11: begin
                mem_we = 1'b1;
                if (empty) begin
                    count_d = count_q + CNT_ONE;
                end else begin
                    mem_waddr = top_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // NOTE: the storage array is deliberately left out of reset; count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= w_data;
        end
    end

`ifdef LIFO_STACK_STICKY_ERR_EN
    logic of_q, uf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            of_q <= 1'b0;
            uf_q <= 1'b0;
        end else begin
            if (wr && !rd && full) begin
                of_q <= 1'b1;
            end
            if (rd && !wr && empty) begin
                uf_q <= 1'b1;
            end
        end
    end

    assign of = of_q;
    assign uf = uf_q;
`else
    assign of = full;
    assign uf = empty;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Randomised scoreboard bench for lifo_stack: a queue-based stack model predicts r_data/of/uf after every operation.
module tb_lifo_stack;

    localparam int WL    = 8;
    localparam int WS    = 4;
    localparam int DEPTH = 1 << WS;

    logic          clk;
    logic          reset;
    logic          rd;
    logic          wr;
    logic [WL-1:0] w_data;
    logic [WL-1:0] r_data;
    logic          of;
    logic          uf;

    lifo_stack #(.WORD_LEN(WL), .WORD_SIZE(WS)) dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .w_data (w_data),
        .r_data (r_data),
        .of     (of),
        .uf     (uf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [WL-1:0] r;
        logic          o;
        logic          u;
    } exp_t;

    exp_t          exp_q[$];
    logic [WL-1:0] stk[$];
    logic          of_err, uf_err;
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: the stack is a plain queue whose back is the top.
    task automatic model_apply(input logic r, input logic w, input logic [WL-1:0] d);
        if (w && !r) begin
            if (stk.size() < DEPTH) stk.push_back(d);
            else of_err = 1'b1;
        end else if (r && !w) begin
            if (stk.size() > 0) void'(stk.pop_back());
            else uf_err = 1'b1;
        end else if (r && w) begin
            if (stk.size() == 0) stk.push_back(d);
            else stk[stk.size()-1] = d;
        end
    endtask

    function automatic exp_t model_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.r   = (stk.size() > 0) ? stk[stk.size()-1] : '0;
`ifdef LIFO_STACK_STICKY_ERR_EN
        e.o   = of_err;
        e.u   = uf_err;
`else
        e.o   = (stk.size() == DEPTH);
        e.u   = (stk.size() == 0);
`endif
        return e;
    endfunction

    task automatic model_reset();
        stk.delete();
        of_err = 1'b0;
        uf_err = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic r, input logic w, input logic [WL-1:0] d);
        @(negedge clk);
        rd     = r;
        wr     = w;
        w_data = d;
        @(posedge clk);
        #1;
        model_apply(r, w, d);
        exp_q.push_back(model_exp(tag));
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic drain_queue();
        int budget;
        budget = 50;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    // Monitor: outputs only move on rising edges or reset, so the falling edge is a stable sample point.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, ".r_data"}, r_data, e.r);
            check({e.tag, ".of"}, of, e.o);
            check({e.tag, ".uf"}, uf, e.u);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks pending %0d", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        w_data = '0;
        model_reset();

        #12;
        check("reset.r_data", r_data, 0);
        check("reset.of", of, 0);
        check("reset.uf", uf, 1);
        reset = 1'b1;

        do_op("pop_after_reset", 1'b1, 1'b0, 8'h00);

        for (int v = 2; v <= 16; v++) begin
            do_op("fill_push", 1'b0, 1'b1, WL'(v));
            do_op("fill_idle", 1'b0, 1'b0, 8'h00);
        end
        do_op("push_to_full", 1'b0, 1'b1, 8'hAA);
        do_op("push_overflow", 1'b0, 1'b1, 8'h55);
        do_op("idle_full", 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < DEPTH; i++) begin
            do_op("drain_pop", 1'b1, 1'b0, 8'h00);
        end
        do_op("pop_underflow", 1'b1, 1'b0, 8'h00);
        do_op("push_after_underflow", 1'b0, 1'b1, 8'h11);
        do_op("pop_to_empty", 1'b1, 1'b0, 8'h00);

        do_op("push5", 1'b0, 1'b1, 8'h05);
        do_op("push6", 1'b0, 1'b1, 8'h06);
        do_op("push7", 1'b0, 1'b1, 8'h07);
        do_op("replace_top", 1'b1, 1'b1, 8'h33);
        for (int i = 0; i < 4; i++) begin
            do_op("pop_after_replace", 1'b1, 1'b0, 8'h00);
        end
        do_op("rdwr_on_empty", 1'b1, 1'b1, 8'h33);
        do_op("pop_single", 1'b1, 1'b0, 8'h00);

        for (int i = 0; i < DEPTH + 2; i++) begin
            do_op("refill", 1'b0, 1'b1, WL'($urandom));
        end
        do_op("replace_when_full", 1'b1, 1'b1, 8'hC3);
        do_op("pop_after_full_replace", 1'b1, 1'b0, 8'h00);

        // Random walk: push-biased then pop-biased so both boundaries get exercised.
        for (int i = 0; i < 600; i++) begin
            int   sel;
            logic r, w;
            sel = $urandom_range(0, 9);
            if (i < 300) begin
                w = (sel < 6);
                r = (sel >= 4 && sel < 8);
            end else begin
                r = (sel < 6);
                w = (sel >= 4 && sel < 8);
            end
            do_op("random", r, w, WL'($urandom));
        end
        drain_queue();

        // Bring the stack back to a known, non-empty state before the asynchronous reset.
        reset = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_op("pre_reset_push", 1'b0, 1'b1, WL'(8'h40 + i));
        end
        drain_queue();
        check("pre_reset.uf", uf, 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset.r_data", r_data, 0);
        check("async_reset.uf", uf, 1);
        check("async_reset.of", of, 0);
        model_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        do_op("idle_after_reset", 1'b0, 1'b0, 8'h00);
        do_op("push_after_reset", 1'b0, 1'b1, 8'h9C);
        drain_queue();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
